wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have `clk  in  1`, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have `reset  in  1`, a synchronous, active-high reset sampled on the rising edge of clk.
REQ-003 The block SHALL have `valid_in_MUL  in  1`, the MUL result-valid signal.
REQ-004 The block SHALL have `ready_out_MUL  out  1`, the MUL result-accepted signal.
REQ-005 The block SHALL have `rd_addr_MUL  in  6` and `rd_data_MUL  in  32`, the MUL destination register and result.
REQ-006 The block SHALL have `valid_in_DIV`, `ready_out_DIV`, `rd_addr_DIV` and `rd_data_DIV`, with the same widths and meanings for DIV.
REQ-007 The block SHALL have `valid_in_FPU`, `ready_out_FPU`, `rd_addr_FPU` and `rd_data_FPU`, with the same widths and meanings for FPU.
REQ-008 The block SHALL have `valid_out  out  1`, signalling that a writeback entry is held for the MEM/WB stage.
REQ-009 The block SHALL have `ready_in  in  1`, signalling that the downstream stage consumes the entry this cycle.
REQ-010 The block SHALL have `rd_addr_WB  out  6` and `rd_data_WB  out  32`, the held writeback destination and data.
REQ-011 The block SHALL have `src_WB  out  2`, the source of the held entry, encoded as a wb_src_t value.

Function
REQ-012 The block SHALL arbitrate the three multi-cycle units onto one registered writeback slot using round-robin priority, in the order MUL -> DIV -> FPU -> MUL.
REQ-013 The grant SHALL depend only on valid_in_* and the priority pointer: the first requester at or after the pointer wins.
REQ-014 The slot SHALL be free when valid_out=0 or ready_in=1 (drain and refill in the same cycle is allowed).
REQ-015 ready_out_X SHALL equal grant_X AND slot free; at most one ready_out_* SHALL be high in any cycle.
REQ-016 On a handshake (valid_in_X and ready_out_X), the next cycle SHALL have valid_out=1, with rd_addr_WB, rd_data_WB and src_WB loaded from X. Latency is 1 cycle.
REQ-017 When the slot is drained (valid_out and ready_in) with no new handshake, valid_out SHALL clear to 0; rd_addr_WB, rd_data_WB and src_WB SHALL clear to 0.
REQ-018 While valid_out=1 and ready_in=0, all outputs SHALL hold stable.
REQ-019 After a handshake with X, the pointer SHALL move to the unit following X; with no handshake, the pointer SHALL hold.
REQ-020 A requester holding valid_in SHALL be accepted within at most 3 slot-free cycles (starvation bound).
REQ-021 The block SHALL NOT drop, duplicate or reorder a transaction from any single source.
REQ-022 rd_addr values, including 0, SHALL pass through unmodified; the register file handles x0 filtering.

Reset
REQ-023 On reset, valid_out SHALL be 0, rd_addr_WB, rd_data_WB and src_WB SHALL be 0, the pointer SHALL be MUL, and all ready_out_* SHALL be 0 in the reset cycle.
REQ-024 A reset asserted with an entry held or a handshake in progress SHALL discard that entry; there SHALL be no output activity in the following cycle.

Configuration
REQ-025 The block SHALL provide macro FPU_WB_EN, which controls the FPU requester.
REQ-026 With FPU_WB_EN defined, the FPU port SHALL be a full requester.
REQ-027 Without FPU_WB_EN, valid_in_FPU SHALL be ignored, ready_out_FPU SHALL be tied to 0, and rotation SHALL be MUL <-> DIV only.
REQ-028 Port lists SHALL be identical in both builds.

Structure
REQ-029 wb_src_t (SRC_MUL=0, SRC_DIV=1, SRC_FPU=2) SHALL reside in CPU_pkg.
REQ-030 The grant logic SHALL be a sub-module, rr_arbiter, with a 3-bit request vector, a 3-bit one-hot grant and a pointer-advance input.
REQ-031 The output slot and pointer registers SHALL reside in wb_arbiter.

Verification
REQ-032 Single MUL request: rd_addr=5, data=0xDEADBEEF, ready_in=1 -> ready_out_MUL=1 in cycle 0; valid_out=1, rd_addr_WB=5, src_WB=0 in cycle 1.
REQ-033 All three units valid continuously with ready_in=1 -> acceptance order MUL, DIV, FPU, MUL, ...; one entry per cycle.
REQ-034 Backpressure: entry held with ready_in=0 for 4 cycles while DIV is valid -> outputs stable and ready_out_DIV=0; on ready_in=1, DIV is accepted in the same cycle.
REQ-035 Reset mid-hold: valid_out=1, then reset pulsed -> valid_out=0 and pointer=MUL; a subsequent FPU+MUL request grants MUL first.
REQ-036 Build without FPU_WB_EN: valid_in_FPU=1 forever -> ready_out_FPU stays 0; MUL and DIV alternate.

Source files
------------

// File: rtl/CPU_pkg.sv
// -----------------------------------------------------------------------------
// CPU_pkg
// Shared types and helpers for the writeback path.
//   wb_src_t  : identifies which multi-cycle unit produced a writeback entry.
//   wb_slot_t : contents of the registered writeback slot.
//   next_src  : round-robin successor of a source, wrapping after num_src units.
// -----------------------------------------------------------------------------
package CPU_pkg;

    localparam int unsigned WB_ADDR_W = 6;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_SRC_N  = 3;

    typedef enum logic [1:0] {
        SRC_MUL = 2'd0,
        SRC_DIV = 2'd1,
        SRC_FPU = 2'd2
    } wb_src_t;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        wb_src_t              src;
    } wb_slot_t;

    // Successor of s in the ring MUL -> DIV [-> FPU] -> MUL.
    function automatic wb_src_t next_src(input wb_src_t s, input int unsigned num_src);
        int unsigned n;
        n = (int'(s) + 1) % num_src;
        return wb_src_t'(n[1:0]);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: the first requester at or after the
// priority pointer wins. The pointer register itself lives in the parent;
// this block only computes the pointer's next value.
// Ports:
//   req_i     [2:0] request vector (bit 0 = MUL, 1 = DIV, 2 = FPU)
//   ptr_i          current priority pointer
//   advance_i      a grant was consumed this cycle; move pointer past winner
//   grant_o   [2:0] one-hot grant (all zero when nothing requests)
//   ptr_d_o        next pointer value
// Parameter NUM_SRC: number of units in the ring (2 or 3); request bits at or
// above NUM_SRC are ignored.
// -----------------------------------------------------------------------------
module rr_arbiter
    import CPU_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3
) (
    input  logic [2:0] req_i,
    input  wb_src_t    ptr_i,
    input  logic       advance_i,
    output logic [2:0] grant_o,
    output wb_src_t    ptr_d_o
);

    logic        found;
    wb_src_t     winner;
    int unsigned idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        winner  = ptr_i;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr_i) + k) % NUM_SRC;
            if (!found && req_i[idx[1:0]]) begin
                found              = 1'b1;
                winner             = wb_src_t'(idx[1:0]);
                grant_o[idx[1:0]]  = 1'b1;
            end
        end
    end

    // advance_i is only raised when some grant was taken, so winner is valid.
    assign ptr_d_o = advance_i ? next_src(winner, NUM_SRC) : ptr_i;

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Merges results from the MUL, DIV and FPU units into one registered
// writeback slot feeding MEM/WB, with round-robin priority.
// Build option: define FPU_WB_EN to make the FPU a requester. Without it the
// FPU inputs are ignored, ready_out_FPU is 0 and the ring is MUL <-> DIV.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   valid_in_X / ready_out_X         per-unit result handshake (X = MUL/DIV/FPU)
//   rd_addr_X [5:0], rd_data_X [31:0] per-unit destination register and result
//   valid_out                        slot holds an entry
//   ready_in                         downstream consumes the entry this cycle
//   rd_addr_WB, rd_data_WB, src_WB   held entry (zero when the slot is empty)
// -----------------------------------------------------------------------------
module wb_arbiter
    import CPU_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        valid_in_MUL,
    output logic        ready_out_MUL,
    input  logic [5:0]  rd_addr_MUL,
    input  logic [31:0] rd_data_MUL,

    input  logic        valid_in_DIV,
    output logic        ready_out_DIV,
    input  logic [5:0]  rd_addr_DIV,
    input  logic [31:0] rd_data_DIV,

    input  logic        valid_in_FPU,
    output logic        ready_out_FPU,
    input  logic [5:0]  rd_addr_FPU,
    input  logic [31:0] rd_data_FPU,

    output logic        valid_out,
    input  logic        ready_in,
    output logic [5:0]  rd_addr_WB,
    output logic [31:0] rd_data_WB,
    output logic [1:0]  src_WB
);

`ifdef FPU_WB_EN
    localparam int unsigned NUM_SRC = 3;
    logic fpu_req;
    assign fpu_req = valid_in_FPU;
`else
    localparam int unsigned NUM_SRC = 2;
    logic fpu_req;
    logic unused_fpu_valid;
    assign fpu_req          = 1'b0;
    assign unused_fpu_valid = valid_in_FPU;
`endif

    wb_slot_t   slot_q, slot_d;
    wb_src_t    ptr_q, ptr_d;
    logic [2:0] req, grant, ready;
    logic       slot_free, handshake;

    assign req = {fpu_req, valid_in_DIV, valid_in_MUL};

    // Drain and refill may happen in the same cycle.
    assign slot_free = !slot_q.valid || ready_in;

    // Grants go only to requesters, so any ready bit is a handshake.
    // Reset suppresses acceptance so an in-flight result is never consumed.
    assign ready     = (slot_free && !reset) ? grant : 3'b000;
    assign handshake = |ready;

    rr_arbiter #(
        .NUM_SRC   (NUM_SRC)
    ) u_rr (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .advance_i (handshake),
        .grant_o   (grant),
        .ptr_d_o   (ptr_d)
    );

    always_comb begin
        slot_d = slot_q;
        if (handshake) begin
            slot_d.valid = 1'b1;
            unique case (1'b1)
                ready[0]: begin
                    slot_d.addr = rd_addr_MUL;
                    slot_d.data = rd_data_MUL;
                    slot_d.src  = SRC_MUL;
                end
                ready[1]: begin
                    slot_d.addr = rd_addr_DIV;
                    slot_d.data = rd_data_DIV;
                    slot_d.src  = SRC_DIV;
                end
                default: begin
                    slot_d.addr = rd_addr_FPU;
                    slot_d.data = rd_data_FPU;
                    slot_d.src  = SRC_FPU;
                end
            endcase
        end else if (slot_q.valid && ready_in) begin
            slot_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs from before the edge, independent of statement order.
    // NOTE: reset is synchronous and clears both the slot and the pointer; a
    // held or incoming entry is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
            ptr_q  <= SRC_MUL;
        end else begin
            slot_q <= slot_d;
            ptr_q  <= ptr_d;
        end
    end

    assign ready_out_MUL = ready[0];
    assign ready_out_DIV = ready[1];
    assign ready_out_FPU = ready[2];

    assign valid_out  = slot_q.valid;
    assign rd_addr_WB = slot_q.addr;
    assign rd_data_WB = slot_q.data;
    assign src_WB     = slot_q.src;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Drives wb_arbiter with directed scenarios and random traffic, comparing
// every cycle against a transaction-level model: one slot, a ring pointer
// held as an integer, and the "first requester at or after the pointer" rule.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

`ifdef FPU_WB_EN
    localparam int NSRC = 3;
`else
    localparam int NSRC = 2;
`endif

    logic        clk;
    logic        reset;
    logic        ready_in;
    logic [2:0]  vin;
    logic [5:0]  addr_in [3];
    logic [31:0] data_in [3];

    logic        ready_out_MUL, ready_out_DIV, ready_out_FPU;
    logic        valid_out;
    logic [5:0]  rd_addr_WB;
    logic [31:0] rd_data_WB;
    logic [1:0]  src_WB;

    wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in_MUL  (vin[0]),
        .ready_out_MUL (ready_out_MUL),
        .rd_addr_MUL   (addr_in[0]),
        .rd_data_MUL   (data_in[0]),
        .valid_in_DIV  (vin[1]),
        .ready_out_DIV (ready_out_DIV),
        .rd_addr_DIV   (addr_in[1]),
        .rd_data_DIV   (data_in[1]),
        .valid_in_FPU  (vin[2]),
        .ready_out_FPU (ready_out_FPU),
        .rd_addr_FPU   (addr_in[2]),
        .rd_data_FPU   (data_in[2]),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .rd_addr_WB    (rd_addr_WB),
        .rd_data_WB    (rd_data_WB),
        .src_WB        (src_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic        m_valid;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;
    int          m_last_win;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check readies, model the edge, check
    // the registered outputs just after it.
    task automatic cyc(input logic r, input logic rdy, input logic [2:0] v, input logic rnd);
        logic       free;
        int         win;
        logic [2:0] exp_rdy;
        @(negedge clk);
        reset    = r;
        ready_in = rdy;
        vin      = v;
        if (rnd) begin
            for (int i = 0; i < 3; i++) begin
                addr_in[i] = 6'($urandom);
                data_in[i] = $urandom;
            end
        end
        #1;
        free = !m_valid || rdy;
        win  = -1;
        if (!r && free) begin
            for (int k = 0; k < NSRC; k++) begin
                int u;
                u = (m_ptr + k) % NSRC;
                if (win < 0 && v[u]) win = u;
            end
        end
        exp_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;
        chk("ready_out", {29'd0, ready_out_FPU, ready_out_DIV, ready_out_MUL}, {29'd0, exp_rdy});
        @(posedge clk);
        m_last_win = win;
        if (r) begin
            m_valid = 0; m_addr = 0; m_data = 0; m_src = 0; m_ptr = 0;
        end else if (win >= 0) begin
            m_valid = 1; m_addr = addr_in[win]; m_data = data_in[win]; m_src = win;
            m_ptr   = (win + 1) % NSRC;
        end else if (m_valid && rdy) begin
            m_valid = 0; m_addr = 0; m_data = 0; m_src = 0;
        end
        #1;
        chk("valid_out",  {31'd0, valid_out},  {31'd0, m_valid});
        chk("rd_addr_WB", {26'd0, rd_addr_WB}, {26'd0, m_addr});
        chk("rd_data_WB", rd_data_WB,          m_data);
        chk("src_WB",     {30'd0, src_WB},     32'(m_src));
    endtask

    int order_q[$];
    int exp_order[6];

    initial begin
        m_valid = 0; m_addr = 0; m_data = 0; m_src = 0; m_ptr = 0; m_last_win = -1;
        reset = 1'b1; ready_in = 1'b0; vin = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_in[i] = '0;
            data_in[i] = '0;
        end

        // Reset state, even with all units requesting.
        cyc(1, 1, 3'b111, 1);
        cyc(1, 1, 3'b000, 1);

        // Single MUL request, latency one cycle; address 0 passes too.
        addr_in[0] = 6'd5; data_in[0] = 32'hDEADBEEF;
        cyc(0, 1, 3'b001, 0);
        chk("single_valid", {31'd0, valid_out}, 32'd1);
        chk("single_addr",  {26'd0, rd_addr_WB}, 32'd5);
        chk("single_data",  rd_data_WB, 32'hDEADBEEF);
        chk("single_src",   {30'd0, src_WB}, 32'd0);
        cyc(0, 1, 3'b000, 1);
        chk("drain_valid", {31'd0, valid_out}, 32'd0);
        addr_in[1] = 6'd0; data_in[1] = 32'h1234_5678;
        cyc(0, 1, 3'b010, 0);
        chk("x0_addr", {26'd0, rd_addr_WB}, 32'd0);

        // All units valid continuously: one entry per cycle in ring order.
        cyc(1, 1, 3'b000, 1);
`ifdef FPU_WB_EN
        exp_order = '{0, 1, 2, 0, 1, 2};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 3'b111, 1);
            order_q.push_back(m_last_win);
            chk("rr_src", {30'd0, src_WB}, 32'(exp_order[i]));
        end
        chk("rr_count", 32'(order_q.size()), 32'd6);

        // Backpressure: held entry stays stable, DIV waits, then goes at once.
        cyc(1, 1, 3'b000, 1);
        cyc(0, 0, 3'b001, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 3'b010, 1);
            chk("bp_hold_src", {30'd0, src_WB}, 32'd0);
        end
        cyc(0, 1, 3'b010, 1);
        chk("bp_div_src", {30'd0, src_WB}, 32'd1);

        // Reset while holding: entry discarded, pointer back to MUL.
        cyc(0, 1, 3'b010, 1);
        cyc(0, 0, 3'b000, 1);
        cyc(1, 0, 3'b101, 1);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        cyc(0, 1, 3'b101, 1);
        chk("rst_mul_first", {30'd0, src_WB}, 32'd0);

        // FPU held valid throughout while MUL/DIV toggle.
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1'($urandom_range(0, 3) != 0), {1'b1, 2'($urandom)}, 1);
        end

        // Random traffic with occasional resets and backpressure.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
                3'($urandom), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
